req_encoder_32to5: RTL
======================

Name: req_encoder_32to5

Overview:
- Sequential 32-to-5 encoder; the inverse direction of the 5-to-32 register-select decoder.
- Captures one-hot or multi-hot request pulses from 32 sources into a sticky pending register.
- Presents one pending source at a time as a 5-bit index over a valid/ready handshake.
- Clears each bit when its index is accepted; used as an event/interrupt-source encoder feeding register-file-indexed logic.

Parameters:
- WIDTH, 32, number of request sources; fixed at 32 in this revision.
- IDX_W, 5, index width, equal to log2(WIDTH).
- RR_EN, 0, 0 = fixed priority (lowest index wins); 1 = round-robin starting after the last granted index.
- CNT_W, 8, width of the saturating coalesce counter.

Ports:
- clk  input  1  clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  32  request pulses; each high bit sets the matching pending bit.
- clr_all  input  1  synchronous flush of all pending state.
- out_valid  output  1  out_idx holds a valid pending source.
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  5  encoded index of the presented source.
- pending  output  32  registered pending vector; includes the presented bit.
- coalesce_cnt  output  CNT_W  saturating count of requests that hit an already-pending bit.

Behaviour:
- Reset: pending=0, out_valid=0, out_idx=0, coalesce_cnt=0, RR pointer=31 (so the first search starts at index 0), state=IDLE.
- Accept: accept = out_valid & out_ready. clr_mask = one-hot(out_idx) when accept, else 0.
- Pending update: pending_next = (pending & ~clr_mask) | req_in.
  - A req_in bit equal to the bit being accepted in the same cycle re-sets it; the new event wins.
- Coalesce: coalesce_cnt increments by 1 per cycle in which (req_in & pending & ~clr_mask) != 0.
  - One increment per cycle, regardless of how many bits hit.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset and clr_all.
- Search vector: pending & ~clr_mask, using registered pending only. Same-cycle req_in is never presented in the cycle it arrives.
- Encoder:
  - RR_EN=0: lowest set bit of the search vector.
  - RR_EN=1: first set bit scanning from (ptr+1) mod 32 upward, wrapping 31 to 0. ptr updates to out_idx on each accept.
- FSM states: IDLE, PRESENT.
  - IDLE: out_valid=0. If pending != 0, register out_idx=enc(pending), set out_valid=1, go to PRESENT.
  - PRESENT: out_valid=1. out_idx and out_valid stay stable while !out_ready.
  - PRESENT on accept with search vector nonzero: load out_idx=enc(search vector), stay in PRESENT. Back-to-back issue, one index per cycle.
  - PRESENT on accept with search vector zero: out_valid=0, go to IDLE.
- Latency:
  - req_in at edge N sets pending at N+1.
  - out_valid rises at N+2 when starting from IDLE.
  - Accept-to-next-index is 0 bubble cycles.
- clr_all has top priority. Next edge: pending=0, out_valid=0, coalesce_cnt=0, state=IDLE; req_in in the same cycle is discarded. RR ptr is kept.
- out_ready while out_valid=0 is ignored.
- Reset asserted mid-handshake: all state returns to reset values immediately (asynchronous). The deassertion edge is synchronised externally.
- All 32 bits pending: 32 consecutive accepts drain the vector.
  - RR_EN=0 grants in order 0..31.
  - RR_EN=1 grants in rotated order.

Decomposition:
- Shared package req_enc_pkg: WIDTH=32, IDX_W=5, state enum {IDLE, PRESENT}, and an onehot32(idx) decode function. The package reuses the team's 5-to-32 decode semantics for clr_mask.
- One combinational sub-module, pri_enc32: inputs vec[31:0], start[4:0], rr_en; outputs idx[4:0], any.
  - Implemented as rotate-by-start, lowest-set-bit encode, then add start mod 32.
  - start is forced to 0 when rr_en=0.

Test Plan:
- Reset, then req_in=0x0000_0001 for one cycle, out_ready=1: out_valid rises 2 cycles later with out_idx=0; pending returns to 0 after the accept; out_valid falls the cycle after.
- RR_EN=0, req_in=0x8000_0014, out_ready=1 held: out_idx sequence 2, 4, 31 on consecutive cycles, then out_valid=0.
- RR_EN=1, grant idx 4, then req_in=0x0000_0011: next grants are 0 and then 4 (scan starts at 5, wraps to 0); a second run with a pending bit at 5 grants 5 first.
- Hold out_ready=0 for 5 cycles with pending=0x0000_0300: out_idx stays 8 and stable; a req_in bit at 9 increments coalesce_cnt to 1; the req_in bit at 8 is re-set while accepted and is re-presented.
- Same-cycle accept of idx 3 and req_in=0x8: bit 3 remains pending and is re-presented; coalesce_cnt unchanged. clr_all with req_in=0xFFFF_FFFF: pending=0, out_valid=0, coalesce_cnt=0 next cycle.
- Drive rst_n low while out_valid=1, asynchronously and mid-cycle: outputs go to 0 immediately, before the next edge; after release, a 256-hit coalesce storm saturates coalesce_cnt at 255.

Source files
------------

// File: rtl/req_enc_pkg.sv
// Shared constants, FSM encodings and the 5-to-32 one-hot decode used by the
// request encoder.
package req_enc_pkg;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;

    // FSM encodings
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    // 5-to-32 decode, same semantics as the register-select decoder
    function automatic logic [WIDTH-1:0] onehot32(input logic [IDX_W-1:0] idx);
        onehot32      = '0;
        onehot32[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/pri_enc32.sv
// Combinational 32-bit priority encoder with optional rotating start point.
// Rotate the vector so 'start' lands at bit 0, find the lowest set bit, then
// add 'start' back (mod 32) to recover the absolute index.
module pri_enc32
    import req_enc_pkg::*;
(
    input  logic [WIDTH-1:0] vec,
    input  logic [IDX_W-1:0] start,
    input  logic             rr_en,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0]   st;
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   rot;
    logic [IDX_W-1:0]   pos;

    assign st  = rr_en ? start : '0;
    assign dbl = {vec, vec};
    assign rot = dbl[{1'b0, st} +: WIDTH];

    // Lowest set bit of the rotated vector; scanning downward lets the
    // lowest hit overwrite any higher one.
    always_comb begin
        pos = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) pos = IDX_W'(i);
        end
    end

    assign any = |vec;
    assign idx = pos + st;

endmodule

// File: rtl/req_encoder_32to5.sv
// Sequential 32-to-5 request encoder. Request pulses accumulate in a sticky
// pending register; one pending source at a time is offered as a 5-bit index
// over valid/ready and its bit is cleared when accepted.
module req_encoder_32to5 #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5,
    parameter int RR_EN = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_in,
    input  logic             clr_all,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] pending,
    output logic [CNT_W-1:0] coalesce_cnt
);

    import req_enc_pkg::*;

    logic [0:0]       state;
    logic [IDX_W-1:0] ptr;
    logic             accept;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] search;
    logic             hit;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    assign out_valid = (state == PRESENT);
    assign accept    = out_valid & out_ready;
    assign clr_mask  = accept ? onehot32(out_idx) : '0;
    // Only registered pending is searched: a request is never offered in
    // the cycle it arrives.
    assign search    = pending & ~clr_mask;
    assign hit       = |(req_in & search);
    // On an accept the grant being retired becomes the new pointer, so the
    // back-to-back search already starts just after it.
    assign start     = (accept ? out_idx : ptr) + IDX_W'(1);

    pri_enc32 u_enc (
        .vec   (search),
        .start (start),
        .rr_en (RR_EN != 0),
        .idx   (enc_idx),
        .any   (enc_any)
    );

    // Sticky pending bits; a new request on the bit being accepted wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pending <= '0;
        else if (clr_all) pending <= '0;
        else              pending <= (pending & ~clr_mask) | req_in;
    end

    // Saturating count of cycles where a request hit an already-pending bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               coalesce_cnt <= '0;
        else if (clr_all)                         coalesce_cnt <= '0;
        else if (hit && coalesce_cnt != '1)       coalesce_cnt <= coalesce_cnt + CNT_W'(1);
    end

    // Round-robin pointer tracks the last accepted index; survives clr_all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ptr <= IDX_W'(WIDTH - 1);
        else if (accept) ptr <= out_idx;
    end

    // IDLE/PRESENT handshake FSM with zero-bubble reload on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            out_idx <= '0;
        end else if (clr_all) begin
            state   <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_any) begin
                        state   <= PRESENT;
                        out_idx <= enc_idx;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        if (enc_any) out_idx <= enc_idx;
                        else         state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
